// File: rtl/adder_seq_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding and chunk-count helpers.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // The operand must split into whole chunks with no remainder.
    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (chunk <= width) && (chunk * nchunk(width, chunk) == width);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into the MSB for overflow detection.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[CHUNK];
    assign cmsb = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the chunk ripple adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_seq.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per clock with a registered carry,
// valid/ready handshake on both sides, result registers updated only on completion.
module adder_seq
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
        $error("adder_seq: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic [WIDTH-1:0]  res;
    logic [WIDTH-1:0]  res_next;
    logic              carry;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_cout;
    logic              chunk_cmsb;
    logic              last;

    assign last = (cnt == CW'(NCHUNK - 1));

    // Operands shift right so the active chunk always sits in the low bits;
    // results enter at the top so after NCHUNK steps they are fully aligned.
    assign res_next = (res >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (opa[CHUNK-1:0]),
        .b    (opb[CHUNK-1:0]),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout),
        .cmsb (chunk_cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    opa   <= opa >> CHUNK;
                    opb   <= opb >> CHUNK;
                    carry <= chunk_cout;
                    res   <= res_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum  <= res_next;
                        cout <= chunk_cout;
                        ovf  <= chunk_cmsb ^ chunk_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
